// File: rtl/toggle_counter_bank.sv
// toggle_counter_bank
// Multi-channel switching-activity monitor. Each channel counts the bit
// transitions on its DW-bit slice of data_in into a saturating counter with
// a sticky saturation flag. A saturating grand total covers all channels.
// Counters are read back through a registered request/address port.
module toggle_counter_bank #(
   parameter int NCH = 4,
   parameter int DW  = 8,
   parameter int CW  = 32,
   // wide enough to address NCH channel counters plus the total counter
   parameter int AW  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enb,
   input  logic                clr,
   input  logic [NCH*DW-1:0]   data_in,
   input  logic                rd_req,
   input  logic [AW-1:0]       rd_addr,
   output logic [CW-1:0]       rd_data,
   output logic                rd_valid,
   output logic [NCH-1:0]      sat,
   output logic                sat_total
);

   // per-channel toggle count range is 0..DW
   localparam int TW = $clog2(DW + 1);
   // sums carry enough headroom that the unclipped value never wraps
   localparam int SW = CW + $clog2(NCH * DW + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [NCH*DW-1:0] prev_q, prev_d;
   logic              primed_q, primed_d;
   logic [CW-1:0]     cnt_q [NCH];
   logic [CW-1:0]     cnt_d [NCH];
   logic [CW-1:0]     total_q, total_d;
   logic [NCH-1:0]    sat_q, sat_d;
   logic              sat_total_q, sat_total_d;
   logic [CW-1:0]     rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic [NCH*DW-1:0] diff;
   logic [TW-1:0]     tog [NCH];
   logic [SW-1:0]     tog_sum;
   logic [SW-1:0]     ch_sum [NCH];
   logic [SW-1:0]     total_sum;
   logic [CW-1:0]     rd_mux;

   // popcount of the bits that changed since the previous sample, per channel and summed
   always_comb begin
      diff    = data_in ^ prev_q;
      tog_sum = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         tog[ch] = '0;
         for (int b = 0; b < DW; b++) begin
            tog[ch] = tog[ch] + TW'(diff[ch*DW + b]);
         end
         tog_sum = tog_sum + SW'(tog[ch]);
      end
   end

   // select the pre-update value of the addressed counter; out-of-range reads return zero
   always_comb begin
      rd_mux = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (rd_addr == AW'(ch)) begin
            rd_mux = cnt_q[ch];
         end
      end
      if (rd_addr == AW'(NCH)) begin
         rd_mux = total_q;
      end
   end

   // next-state: history always tracks, clear beats counting, counting clips at the max
   always_comb begin
      prev_d      = data_in;
      primed_d    = 1'b1;
      cnt_d       = cnt_q;
      total_d     = total_q;
      sat_d       = sat_q;
      sat_total_d = sat_total_q;
      total_sum   = SW'(total_q) + tog_sum;
      for (int ch = 0; ch < NCH; ch++) begin
         ch_sum[ch] = SW'(cnt_q[ch]) + SW'(tog[ch]);
      end

      if (clr) begin
         for (int ch = 0; ch < NCH; ch++) begin
            cnt_d[ch] = '0;
         end
         total_d     = '0;
         sat_d       = '0;
         sat_total_d = 1'b0;
      end else if (enb && primed_q) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (ch_sum[ch] > SW'(CNT_MAX)) begin
               cnt_d[ch] = CNT_MAX;
               sat_d[ch] = 1'b1;
            end else begin
               cnt_d[ch] = ch_sum[ch][CW-1:0];
            end
         end
         if (total_sum > SW'(CNT_MAX)) begin
            total_d     = CNT_MAX;
            sat_total_d = 1'b1;
         end else begin
            total_d = total_sum[CW-1:0];
         end
      end

      rd_valid_d = rd_req;
      rd_data_d  = rd_req ? rd_mux : rd_data_q;
   end

   // state registers with synchronous reset, which also drops any in-flight read
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= '0;
         primed_q    <= 1'b0;
         cnt_q       <= '{default: '0};
         total_q     <= '0;
         sat_q       <= '0;
         sat_total_q <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         primed_q    <= primed_d;
         cnt_q       <= cnt_d;
         total_q     <= total_d;
         sat_q       <= sat_d;
         sat_total_q <= sat_total_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign sat       = sat_q;
   assign sat_total = sat_total_q;

endmodule

// File: tb/tb_toggle_counter_bank.sv
// tb_toggle_counter_bank
// Drives a wide (CW=32) and a narrow (CW=4) toggle_counter_bank with the same
// stimulus and compares both against a behavioural popcount model every cycle.
module tb_toggle_counter_bank;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int AW  = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            enb;
   logic            clr;
   logic [31:0]     data_in;
   logic            rd_req;
   logic [AW-1:0]   rd_addr;

   logic [31:0]     rd_data_a;
   logic            rd_valid_a;
   logic [NCH-1:0]  sat_a;
   logic            sat_total_a;
   logic [3:0]      rd_data_b;
   logic            rd_valid_b;
   logic [NCH-1:0]  sat_b;
   logic            sat_total_b;

   int checks = 0;
   int errors = 0;

   // behavioural model state, index 0 = wide instance, index 1 = narrow instance
   longint          m_cnt [2][NCH];
   longint          m_total [2];
   logic [NCH-1:0]  m_sat [2];
   logic            m_sat_total [2];
   longint          m_rd_data [2];
   logic            m_rd_valid;
   logic [31:0]     m_prev;
   logic            m_primed;
   longint          maxv [2];
   logic [31:0]     cur_data;

   toggle_counter_bank #(.NCH(NCH), .DW(DW), .CW(32), .AW(AW)) dut_wide (
      .clk(clk), .rst(rst), .enb(enb), .clr(clr), .data_in(data_in),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .sat(sat_a), .sat_total(sat_total_a)
   );

   toggle_counter_bank #(.NCH(NCH), .DW(DW), .CW(4), .AW(AW)) dut_narrow (
      .clk(clk), .rst(rst), .enb(enb), .clr(clr), .data_in(data_in),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .sat(sat_b), .sat_total(sat_total_b)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // model advance for one rising edge using the inputs sampled at that edge
   task automatic modelStep();
      longint t;
      longint grand;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < NCH; ch++) m_cnt[i][ch] = 0;
            m_total[i] = 0; m_sat[i] = '0; m_sat_total[i] = 1'b0; m_rd_data[i] = 0;
         end
         m_rd_valid = 1'b0; m_prev = '0; m_primed = 1'b0;
      end else begin
         m_rd_valid = rd_req;
         if (rd_req) begin
            for (int i = 0; i < 2; i++) begin
               if (int'(rd_addr) < NCH)       m_rd_data[i] = m_cnt[i][rd_addr];
               else if (int'(rd_addr) == NCH) m_rd_data[i] = m_total[i];
               else                           m_rd_data[i] = 0;
            end
         end
         if (clr) begin
            for (int i = 0; i < 2; i++) begin
               for (int ch = 0; ch < NCH; ch++) m_cnt[i][ch] = 0;
               m_total[i] = 0; m_sat[i] = '0; m_sat_total[i] = 1'b0;
            end
         end else if (enb && m_primed) begin
            grand = 0;
            for (int ch = 0; ch < NCH; ch++) begin
               t = $countones(data_in[ch*DW +: DW] ^ m_prev[ch*DW +: DW]);
               grand += t;
               for (int i = 0; i < 2; i++) begin
                  if (m_cnt[i][ch] + t > maxv[i]) begin
                     m_cnt[i][ch] = maxv[i]; m_sat[i][ch] = 1'b1;
                  end else m_cnt[i][ch] = m_cnt[i][ch] + t;
               end
            end
            for (int i = 0; i < 2; i++) begin
               if (m_total[i] + grand > maxv[i]) begin
                  m_total[i] = maxv[i]; m_sat_total[i] = 1'b1;
               end else m_total[i] = m_total[i] + grand;
            end
         end
         m_prev = data_in;
         m_primed = 1'b1;
      end
   endtask

   task automatic checkOutput();
      checkValue("rd_valid_wide", 64'(rd_valid_a), 64'(m_rd_valid));
      checkValue("rd_valid_narrow", 64'(rd_valid_b), 64'(m_rd_valid));
      checkValue("rd_data_wide", 64'(rd_data_a), 64'(m_rd_data[0]));
      checkValue("rd_data_narrow", 64'(rd_data_b), 64'(m_rd_data[1]));
      checkValue("sat_wide", 64'(sat_a), 64'(m_sat[0]));
      checkValue("sat_narrow", 64'(sat_b), 64'(m_sat[1]));
      checkValue("sat_total_wide", 64'(sat_total_a), 64'(m_sat_total[0]));
      checkValue("sat_total_narrow", 64'(sat_total_b), 64'(m_sat_total[1]));
   endtask

   // one clock: drive inputs, let the edge happen, advance the model, compare
   task automatic applyStimulus(input logic r, input logic e, input logic c,
                                input logic [31:0] d, input logic rq, input logic [AW-1:0] a);
      rst = r; enb = e; clr = c; data_in = d; rd_req = rq; rd_addr = a;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic step(input logic [31:0] d);
      cur_data = d;
      applyStimulus(1'b0, 1'b1, 1'b0, d, 1'b0, '0);
   endtask

   task automatic readAddr(input logic [AW-1:0] a);
      applyStimulus(1'b0, 1'b1, 1'b0, cur_data, 1'b1, a);
   endtask

   task automatic doReset();
      cur_data = '0;
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
   endtask

   // directed scenarios followed by a randomized soak, all checked against the model
   initial begin
      maxv[0] = 64'h0000_0000_FFFF_FFFF;
      maxv[1] = 15;
      rst = 1'b1; enb = 1'b0; clr = 1'b0; data_in = '0; rd_req = 1'b0; rd_addr = '0;
      cur_data = '0;
      #2;

      $display("[TB] test 1: reset and idle reads");
      doReset();
      checkValue("t1_reset_rd_valid", 64'(rd_valid_a), 64'd0);
      checkValue("t1_reset_rd_data", 64'(rd_data_a), 64'd0);
      for (int i = 0; i < 5; i++) step('0);
      for (int a = 0; a < 8; a++) begin
         readAddr(AW'(a));
         checkValue("t1_rd_zero", 64'(rd_data_a), 64'd0);
      end

      $display("[TB] test 2: priming and basic counting");
      doReset();
      step(32'h0000_00FF);
      step(32'h0000_0000);
      step(32'h0000_00CC);
      step(32'h0000_00AB);
      step(32'h0000_0025);
      // 8 + 4 + 5 + 4 toggles on ch0 after the uncounted first sample
      readAddr(3'd0);
      checkValue("t2_cnt0", 64'(rd_data_a), 64'd21);
      readAddr(3'd4);
      checkValue("t2_total", 64'(rd_data_a), 64'd21);

      $display("[TB] test 3: saturation on the narrow instance");
      doReset();
      step(32'h0000_0000);
      step(32'h0000_FF00);
      checkValue("t3_no_sat_yet", 64'(sat_b), 64'd0);
      step(32'h0000_0000);
      checkValue("t3_sat1", 64'(sat_b), 64'h2);
      checkValue("t3_sat_total", 64'(sat_total_b), 64'd1);
      step(32'h0000_FF00);
      readAddr(3'd1);
      checkValue("t3_cnt1_narrow", 64'(rd_data_b), 64'd15);
      checkValue("t3_cnt1_wide", 64'(rd_data_a), 64'd24);
      readAddr(3'd4);
      checkValue("t3_total_narrow", 64'(rd_data_b), 64'd15);

      $display("[TB] test 4: clear with concurrent toggles");
      doReset();
      step(32'h000F_0000);
      step(32'h00F0_0000);
      step(32'h000F_0000);
      checkValue("t4_sat_before_clr", 64'(sat_b), 64'h4);
      cur_data = 32'h00F0_0000;
      applyStimulus(1'b0, 1'b1, 1'b1, cur_data, 1'b0, '0);
      checkValue("t4_sat_cleared", 64'(sat_b), 64'd0);
      step(32'h00F0_0000);
      step(32'h0000_0000);
      readAddr(3'd2);
      checkValue("t4_cnt2", 64'(rd_data_a), 64'd4);
      readAddr(3'd4);
      checkValue("t4_total", 64'(rd_data_b), 64'd4);

      $display("[TB] test 5: enable gating");
      doReset();
      step(32'h0000_0000);
      cur_data = 32'hFF00_0000;
      applyStimulus(1'b0, 1'b0, 1'b0, cur_data, 1'b0, '0);
      step(32'hFF00_0000);
      step(32'hFF00_0000);
      readAddr(3'd3);
      checkValue("t5_cnt3", 64'(rd_data_a), 64'd0);

      $display("[TB] test 6: concurrent read and count, reset mid-read");
      doReset();
      step(32'h0000_0000);
      step(32'h0000_00FF);
      step(32'h0000_00FC);
      cur_data = 32'h0000_00FF;
      applyStimulus(1'b0, 1'b1, 1'b0, cur_data, 1'b1, 3'd0);
      checkValue("t6_read_pre", 64'(rd_data_a), 64'd10);
      readAddr(3'd0);
      checkValue("t6_read_post", 64'(rd_data_a), 64'd12);
      readAddr(3'd6);
      checkValue("t6_read_oob", 64'(rd_data_a), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, cur_data, 1'b1, 3'd0);
      checkValue("t6_rst_drops_read", 64'(rd_valid_a), 64'd0);
      step(32'h5A5A_5A5A);
      readAddr(3'd4);
      checkValue("t6_reprime_total", 64'(rd_data_a), 64'd0);

      $display("[TB] random soak");
      doReset();
      for (int n = 0; n < 1000; n++) begin
         applyStimulus(($urandom_range(199, 0) == 0),
                       ($urandom_range(3, 0) != 0),
                       ($urandom_range(19, 0) == 0),
                       $urandom,
                       ($urandom_range(1, 0) == 1),
                       AW'($urandom_range(7, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
